// File: rtl/au_pkg.sv
// au_pkg: shared Gray conversion and index-width helpers for the Gray arbiter.
package au_pkg;

   function automatic logic [31:0] gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic int idw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/au_bin2gray.sv
// au_bin2gray: combinational binary-to-Gray converter of parameterised width.
module au_bin2gray
   import au_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] g
);

   assign g = WIDTH'(gray(32'(b)));

endmodule

// File: rtl/au_bin2gray_arb.sv
// au_bin2gray_arb: round-robin arbiter sharing one Gray converter, one-entry output buffer.
module au_bin2gray_arb
   import au_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 2,
   localparam int IDW  = idw(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       in_valid,
   input  logic [NREQ*WIDTH-1:0] in_b,
   output logic [NREQ-1:0]       in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_g,
   output logic [IDW-1:0]        out_id
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [WIDTH-1:0]  g_q, g_d;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    gidx;
   logic              found;
   logic              free;
   logic              xfer;
   int                k;
   logic [WIDTH-1:0]  sel_b;
   logic [WIDTH-1:0]  sel_g;

   // search from ptr upward, wrapping to 0; first valid requester wins
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      k     = 0;
      for (int j = 0; j < NREQ; j++) begin
         k = (int'(ptr_q) + j) % NREQ;
         if (!found && in_valid[k]) begin
            grant[k] = 1'b1;
            gidx     = IDW'(k);
            found    = 1'b1;
         end
      end
   end

   assign free     = (state_q == EMPTY) || out_ready;
   assign in_ready = grant & {NREQ{free & rst_n}};
   assign xfer     = |in_ready;
   assign sel_b    = in_b[gidx*WIDTH +: WIDTH];

   au_bin2gray #(.WIDTH(WIDTH)) u_conv (
      .b (sel_b),
      .g (sel_g)
   );

   always_comb begin
      state_d = xfer ? FULL : ((state_q == FULL && !out_ready) ? FULL : EMPTY);
      g_d     = xfer ? sel_g : g_q;
      id_d    = xfer ? gidx : id_q;
      ptr_d   = !xfer ? ptr_q : ((gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         id_q    <= '0;
         g_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         g_q     <= g_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_g     = g_q;
   assign out_id    = id_q;

endmodule

// File: tb/tb_au_bin2gray_arb.sv
// tb_au_bin2gray_arb: vector table plus scoreboard of expected output words, NREQ=4, WIDTH=8.
module tb_au_bin2gray_arb;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_b;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_g;
   logic [1:0]     out_id;

   typedef struct {
      logic [N-1:0]   v;
      logic [N*W-1:0] b;
      logic           ordy;
      logic [N-1:0]   rdy;
   } vec_t;

   typedef struct {
      logic [1:0]   id;
      logic [W-1:0] g;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[19];
   int   checks = 0;
   int   failures = 0;

   au_bin2gray_arb #(.WIDTH(W), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_b      (in_b),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_g     (out_g),
      .out_id    (out_id)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
      return b ^ {1'b0, b[W-1:1]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // one clock: drive at posedge+1, check at negedge, push accepted words for the next cycle
   task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] b, input logic ordy, input logic [N-1:0] rdy);
      exp_t e;
      in_valid  = v;
      in_b      = b;
      out_ready = ordy;
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk("out_g", 32'(out_g), 32'(sb[0].g));
         chk("out_id", 32'(out_id), 32'(sb[0].id));
         if (ordy) void'(sb.pop_front());
      end
      for (int i = 0; i < N; i++)
         if (rdy[i]) begin
            e.id = 2'(i);
            e.g  = ref_gray(b[i*W +: W]);
            sb.push_back(e);
         end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = '1;
      in_b      = '1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_g", 32'(out_g), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      in_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
   endtask

   initial begin
      logic [N*W-1:0] b;
      tbl[0]  = '{4'b0011, 32'h0000_80FF, 1'b1, 4'b0001};
      tbl[1]  = '{4'b0011, 32'h0000_80FF, 1'b1, 4'b0010};
      tbl[2]  = '{4'b0011, 32'h0000_80FF, 1'b1, 4'b0001};
      tbl[3]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000};
      tbl[4]  = '{4'b0001, 32'h0000_0005, 1'b1, 4'b0001};
      tbl[5]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000};
      tbl[6]  = '{4'b0100, 32'h0033_0000, 1'b1, 4'b0100};
      tbl[7]  = '{4'b0011, 32'h0000_3412, 1'b1, 4'b0001};
      tbl[8]  = '{4'b0011, 32'h0000_3412, 1'b1, 4'b0010};
      tbl[9]  = '{4'b1000, 32'hA500_0000, 1'b0, 4'b0000};
      tbl[10] = '{4'b1000, 32'hA500_0000, 1'b0, 4'b0000};
      tbl[11] = '{4'b1000, 32'hA500_0000, 1'b0, 4'b0000};
      tbl[12] = '{4'b1000, 32'hA500_0000, 1'b0, 4'b0000};
      tbl[13] = '{4'b1000, 32'hA500_0000, 1'b0, 4'b0000};
      tbl[14] = '{4'b1000, 32'hA500_0000, 1'b1, 4'b1000};
      tbl[15] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000};
      tbl[16] = '{4'b0010, 32'h0000_0100, 1'b0, 4'b0010};
      tbl[17] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000};
      tbl[18] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000};

      do_reset();
      for (int i = 0; i < 19; i++) cyc(tbl[i].v, tbl[i].b, tbl[i].ordy, tbl[i].rdy);

      // every value from every requester, other slices randomised to exercise the mux
      for (int r = 0; r < N; r++)
         for (int val = 0; val < (1 << W); val++) begin
            b = $urandom;
            b[r*W +: W] = W'(val);
            cyc(N'(1 << r), b, 1'b1, N'(1 << r));
         end
      cyc('0, '0, 1'b1, '0);

      // asynchronous reset while FULL and stalled
      do_reset();
      cyc(4'b0001, 32'h0000_005A, 1'b0, 4'b0001);
      cyc(4'b0100, 32'h00CC_0000, 1'b0, 4'b0000);
      in_valid = 4'b0101;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_g", 32'(out_g), 32'd0);
      chk("mid_rst_out_id", 32'(out_id), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      sb.delete();
      in_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(4'b0101, 32'h0033_0011, 1'b1, 4'b0001);
      cyc(4'b0101, 32'h0033_0011, 1'b1, 4'b0100);
      cyc(4'b0000, 32'h0000_0000, 1'b1, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/au_bin2gray_arb.md
AU_BIN2GRAY_ARB -- requirements
Module: AU_bin2gray_arb

Interface
REQ-001 Parameter WIDTH, default 8: word length of binary input and Gray output, legal range 1..32.
REQ-002 Parameter NREQ, default 2: number of requesters, legal range 2..8.
REQ-003 Localparam IDW = $clog2(NREQ): width of the requester index.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port in_valid, input, NREQ: bit i set means requester i presents a word.
REQ-007 Port in_b, input, NREQ*WIDTH: binary words; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 Port in_ready, output, NREQ: bit i set means requester i's word is accepted this cycle.
REQ-009 Port out_valid, output, 1: the output register holds a converted word.
REQ-010 Port out_ready, input, 1: the consumer accepts the output word.
REQ-011 Port out_g, output, WIDTH: Gray code of the accepted word, out_g = b ^ (b >> 1).
REQ-012 Port out_id, output, IDW: index of the requester that supplied out_g.

Function
REQ-013 The block shall share one binary-to-Gray converter among NREQ requesters using round-robin arbitration.
REQ-014 Output buffer state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 The stage shall be free when in EMPTY, or in FULL with out_ready=1.
REQ-016 The grant shall be one-hot over in_valid, with the search starting at index ptr and wrapping from NREQ-1 to 0.
REQ-017 in_ready shall equal grant AND free; at most one in_ready bit shall be set per cycle.
REQ-018 in_ready shall be combinational from in_valid, ptr, out_valid and out_ready, and independent of in_b.
REQ-019 On transfer (in_valid[k] & in_ready[k]), the next edge shall load out_g = gray(in_b slice k) and out_id = k, and enter FULL.
REQ-020 On transfer from requester k, ptr shall become (k+1) mod NREQ; ptr shall not change on any cycle without a transfer.
REQ-021 In FULL with out_ready=1 and no new transfer, the state shall return to EMPTY.
REQ-022 In FULL with out_ready=1 and a new transfer in the same cycle, the state shall stay FULL with the new word, giving back-to-back throughput of one word per cycle.
REQ-023 In FULL with out_ready=0, out_g and out_id shall hold stable and all in_ready bits shall be 0.
REQ-024 Latency from input transfer to out_valid shall be exactly 1 cycle.
REQ-025 With no in_valid bits set, there shall be no grant and ptr shall hold.
REQ-026 The arbiter shall be fair: a continuously valid requester shall be served within NREQ transfers.
REQ-027 Requesters shall hold in_valid and their in_b slice stable until in_ready; the block shall not check this.

Reset
REQ-028 Asserting rst_n low shall immediately clear out_valid, out_g, out_id and ptr to 0, including in the middle of a transfer.
REQ-029 In_ready shall be 0 for all requesters while rst_n is low.
REQ-030 The first arbitration after reset release shall give requester 0 highest priority.

Structure
REQ-031 A shared package AU_pkg shall hold the Gray conversion function and the IDW helper; there shall be no other typedefs.
REQ-032 Conversion shall be done by one instance of sub-module AU_bin2gray (parameter WIDTH) on the muxed granted word.
REQ-033 The output register shall use only the clk and rst_n domain; there shall be no latches.

Verification
REQ-034 Single requester: WIDTH=8, requester 0 sends b=8'h05 with out_ready=1 -> next cycle out_valid=1, out_g=8'h07, out_id=0.
REQ-035 Contention: NREQ=2, both valid with b0=8'hFF and b1=8'h80, out_ready=1 -> outputs alternate id0 g=8'h80, then id1 g=8'hC0, one word per cycle.
REQ-036 Backpressure: FULL with out_ready=0 for 5 cycles -> out_g and out_id stable, in_ready=0; release -> the pending requester is accepted in the same cycle.
REQ-037 Wrap-around: NREQ=4, ptr=3, valid={0,1} -> grant to 0, then ptr=1.
REQ-038 Reset mid-operation: assert rst_n while FULL -> out_valid=0 at once; after release, requesters 0 and 2 both valid -> 0 is granted first.
REQ-039 Exhaustive: for WIDTH<=16, all 2^WIDTH values from each requester are checked against the reference model; the bench reports PASS with the total count.
